// File: rtl/axi_full_slave_mem.sv
// AXI4-full slave backed by a word-addressed memory array. One burst (INCR or
// FIXED) in flight at a time; bad size/burst or out-of-range beats return SLVERR.
module axi_full_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);
  localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDXW  = $clog2(C_MEM_DEPTH);
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam logic [2:0]  SIZE_OK   = 3'(LSB);
  localparam logic [AW:0] MEM_BYTES = (AW+1)'(C_MEM_DEPTH * BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;
  state_t state_q, state_d;

  logic [DW-1:0] mem [C_MEM_DEPTH];

  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]               addr_q;
  logic [7:0]                  len_q, cnt_q;
  logic                        fixed_q, size_err_q, err_acc_q, last_grant_rd_q;
  logic                        rvalid_q, rlast_q;
  logic [DW-1:0]               rdata_q;
  logic [1:0]                  rresp_q;

  // INCR steps only the low 12 bits so a burst wraps inside its 4KB page.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic fixed);
    next_addr = fixed ? a : {a[AW-1:12], a[11:0] + 12'(BYTES)};
  endfunction

  function automatic logic out_of_range(input logic [AW-1:0] a);
    out_of_range = {1'b0, a} >= MEM_BYTES;
  endfunction

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    bad_req = (size != SIZE_OK) || burst[1];
  endfunction

  logic idle, aw_hs, ar_hs, w_hs, r_hs, w_beat_last, w_bad, rd_bad, contend;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_word;

  assign idle    = (state_q == S_IDLE) && !S_AXI_ARESET;
  assign contend = S_AXI_AWVALID && S_AXI_ARVALID;

  // On contention the side that did not win last time is granted.
  assign S_AXI_AWREADY = idle && !(S_AXI_ARVALID && !last_grant_rd_q);
  assign S_AXI_ARREADY = idle && !(S_AXI_AWVALID && last_grant_rd_q);
  assign S_AXI_WREADY  = (state_q == S_WDATA) && !S_AXI_ARESET;
  assign S_AXI_BVALID  = (state_q == S_WRESP) && !S_AXI_ARESET;
  assign S_AXI_BRESP   = (S_AXI_BVALID && err_acc_q) ? 2'b10 : 2'b00;
  assign S_AXI_BID     = S_AXI_BVALID ? id_q : '0;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = rvalid_q ? id_q : '0;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign r_hs  = rvalid_q && S_AXI_RREADY;

  assign w_beat_last = (cnt_q == len_q);
  assign w_bad       = size_err_q || out_of_range(addr_q);

  // Read beat source: the AR address on the handshake, else the next beat.
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? S_AXI_ARADDR : next_addr(addr_q, fixed_q);
    rd_bad  = ((state_q == S_IDLE) ? bad_req(S_AXI_ARSIZE, S_AXI_ARBURST) : size_err_q)
              || out_of_range(rd_addr);
    rd_word = mem[rd_addr[LSB +: IDXW]];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (aw_hs) state_d = S_WDATA;
               else if (ar_hs) state_d = S_RDATA;
      S_WDATA: if (w_hs && w_beat_last) state_d = S_WRESP;
      S_WRESP: if (S_AXI_BREADY) state_d = S_IDLE;
      S_RDATA: if (r_hs && rlast_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      fixed_q         <= 1'b0;
      size_err_q      <= 1'b0;
      err_acc_q       <= 1'b0;
      last_grant_rd_q <= 1'b1;
      rvalid_q        <= 1'b0;
      rlast_q         <= 1'b0;
      rdata_q         <= '0;
      rresp_q         <= 2'b00;
    end else begin
      if (idle && contend) last_grant_rd_q <= ar_hs;
      if (aw_hs) begin
        id_q       <= S_AXI_AWID;
        addr_q     <= S_AXI_AWADDR;
        len_q      <= S_AXI_AWLEN;
        cnt_q      <= '0;
        fixed_q    <= (S_AXI_AWBURST == 2'b00);
        size_err_q <= bad_req(S_AXI_AWSIZE, S_AXI_AWBURST);
        err_acc_q  <= 1'b0;
      end else if (ar_hs) begin
        id_q       <= S_AXI_ARID;
        addr_q     <= S_AXI_ARADDR;
        len_q      <= S_AXI_ARLEN;
        cnt_q      <= '0;
        fixed_q    <= (S_AXI_ARBURST == 2'b00);
        size_err_q <= bad_req(S_AXI_ARSIZE, S_AXI_ARBURST);
        rvalid_q   <= 1'b1;
        rdata_q    <= rd_bad ? '0 : rd_word;
        rresp_q    <= rd_bad ? 2'b10 : 2'b00;
        rlast_q    <= (S_AXI_ARLEN == 8'd0);
      end
      if (w_hs) begin
        cnt_q  <= 8'(cnt_q + 8'd1);
        addr_q <= next_addr(addr_q, fixed_q);
        if ((S_AXI_WLAST != w_beat_last) || w_bad) err_acc_q <= 1'b1;
      end
      if (r_hs) begin
        if (rlast_q) begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
          rdata_q  <= '0;
          rresp_q  <= 2'b00;
        end else begin
          addr_q  <= rd_addr;
          cnt_q   <= 8'(cnt_q + 8'd1);
          rdata_q <= rd_bad ? '0 : rd_word;
          rresp_q <= rd_bad ? 2'b10 : 2'b00;
          rlast_q <= (8'(cnt_q + 8'd1) == len_q);
        end
      end
    end
  end

  // Array has no reset so contents survive S_AXI_ARESET.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_hs && !w_bad) begin
      for (int b = 0; b < BYTES; b++)
        if (S_AXI_WSTRB[b]) mem[addr_q[LSB +: IDXW]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end

endmodule
